// File: rtl/vga_pkg.sv
// Shared definitions for the parametrised VGA timing controller:
// FSM and mode encodings, the per-pixel pipeline tag, default 640x480@60
// timing and the colour-bar lookup.
package vga_pkg;

  // Default 640x480@60 timing with a 25 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // The test pattern is always eight bars across the visible line
  localparam int BAR_COUNT = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vga_state_e;

  typedef enum logic {
    MODE_FB   = 1'b0,
    MODE_BARS = 1'b1
  } vga_mode_e;

  // Everything the output stage needs about one pixel slot; this travels
  // through the delay line so it lines up with the frame-buffer data.
  typedef struct packed {
    logic      active;
    logic      hs;
    logic      vs;
    vga_mode_e mode;
    logic [2:0] bar;    // {red_on, green_on, blue_on}
  } vid_tag_t;

  // Bar colour as on/off per channel; replicated to COLOR_W bits at the
  // output so the same table serves every colour depth.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;  // white
      3'd1:    m = 3'b110;  // yellow
      3'd2:    m = 3'b011;  // cyan
      3'd3:    m = 3'b010;  // green
      3'd4:    m = 3'b101;  // magenta
      3'd5:    m = 3'b100;  // red
      3'd6:    m = 3'b001;  // blue
      default: m = 3'b000;  // black
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with an asynchronous reset value. DEPTH = 0
// degenerates to a wire so callers can absorb a zero-cycle memory latency.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_reg [DEPTH];

      // Shift one stage per clock; reset loads every stage with RST_VAL
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= RST_VAL;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl_p.sv
// Parametrised VGA timing generator. Counters and decode run at cycle t,
// the frame-buffer address leaves at t+1, the memory answers RD_LAT cycles
// later and sync/enable/RGB leave together at t+2+RD_LAT.
module vga_timing_ctrl_p
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   COLOR_W     = 4,
  parameter int   SRC_W       = 640,
  parameter int   SCALE_SHIFT = 0,
  parameter int   ADDR_W      = 19,
  parameter int   RD_LAT      = 1
) (
  input  logic                   CLK_25_I,
  input  logic                   RST_N_I,
  input  logic                   ENABLE_I,
  input  logic                   MODE_I,
  input  logic [3*COLOR_W-1:0]   VIDEO_PXL_I,
  output logic [ADDR_W-1:0]      ADDRESS_O,
  output logic                   FRAME_START_O,
  output logic [COLOR_W-1:0]     RED_O,
  output logic [COLOR_W-1:0]     GREEN_O,
  output logic [COLOR_W-1:0]     BLUE_O,
  output logic                   HSYNC_O,
  output logic                   VSYNC_O,
  output logic                   VIDEO_EN_O
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare code so the sync end boundary is representable with zero porch
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int BAR_W = H_ACTIVE / BAR_COUNT;
  localparam int TAG_W = $bits(vid_tag_t);

  // ---------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------
  vga_state_e     state_reg, state_next;
  logic [HW-1:0]  h_cnt_reg, h_cnt_next;
  logic [VW-1:0]  v_cnt_reg, v_cnt_next;

  logic           running;
  logic           at_origin;
  logic           h_wrap;
  logic           v_wrap;
  logic           at_last;
  logic [HW-1:0]  h_adv;
  logic [VW-1:0]  v_adv;

  assign running   = (state_reg != ST_IDLE);
  assign at_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign h_wrap    = (h_cnt_reg == H_LAST);
  assign v_wrap    = (v_cnt_reg == V_LAST);
  assign at_last   = h_wrap && v_wrap;
  assign h_adv     = h_wrap ? '0 : h_cnt_reg + HW'(1);
  assign v_adv     = h_wrap ? (v_wrap ? '0 : v_cnt_reg + VW'(1)) : v_cnt_reg;

  // State register and raster counters
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_reg <= ST_IDLE;
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Next state: stop requests only take effect on the last pixel of a frame
  always_comb begin
    state_next = state_reg;
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        h_cnt_next = '0;
        v_cnt_next = '0;
        if (ENABLE_I) state_next = ST_RUN;
      end
      ST_RUN: begin
        h_cnt_next = h_adv;
        v_cnt_next = v_adv;
        if (!ENABLE_I) state_next = ST_STOPPING;
      end
      ST_STOPPING: begin
        h_cnt_next = h_adv;
        v_cnt_next = v_adv;
        if (ENABLE_I)     state_next = ST_RUN;
        else if (at_last) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        h_cnt_next = '0;
        v_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Decode at cycle t
  // ---------------------------------------------------------------------
  vga_mode_e  mode_reg;
  vga_mode_e  mode_now;
  logic [6:0] bar_thermo;
  logic [2:0] bar_idx;
  vid_tag_t   tag_now;
  logic [ADDR_W-1:0] addr_now;

  // Mode only changes hands at the frame origin so a frame is never split
  assign mode_now = at_origin ? vga_mode_e'(MODE_I) : mode_reg;

  // Bar boundaries as a thermometer code; avoids a divider on h
  for (genvar gi = 0; gi < BAR_COUNT - 1; gi++) begin : g_bar_edge
    localparam logic [HW-1:0] EDGE = HW'((gi + 1) * BAR_W);
    assign bar_thermo[gi] = (h_cnt_reg >= EDGE);
  end

  // Count thermometer ones to get the bar index
  always_comb begin
    bar_idx = '0;
    for (int i = 0; i < BAR_COUNT - 1; i++) begin
      bar_idx = bar_idx + {2'b00, bar_thermo[i]};
    end
  end

  // Per-pixel flags; everything is forced inactive while idle
  always_comb begin
    tag_now        = '0;
    tag_now.active = running && (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    tag_now.hs     = running && (h_cnt_reg >= HS_BEGIN) && (h_cnt_reg < HS_END);
    tag_now.vs     = running && (v_cnt_reg >= VS_BEGIN) && (v_cnt_reg < VS_END);
    tag_now.mode   = mode_now;
    tag_now.bar    = bar_mask(bar_idx);
  end

  // Scaled source address; arithmetic in ADDR_W bits gives the truncation
  assign addr_now = ADDR_W'(v_cnt_reg >> SCALE_SHIFT) * ADDR_W'(SRC_W)
                  + ADDR_W'(h_cnt_reg >> SCALE_SHIFT);

  // ---------------------------------------------------------------------
  // Stage 1 (t+1): address, frame pulse, pixel tag
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] address_reg;
  logic              frame_start_reg;
  vid_tag_t          tag_s1_reg;

  // Register address/tag; address holds through blanking
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      address_reg     <= '0;
      frame_start_reg <= 1'b0;
      tag_s1_reg      <= '0;
      mode_reg        <= MODE_FB;
    end else begin
      if (tag_now.active) address_reg <= addr_now;
      frame_start_reg <= running && at_origin;
      tag_s1_reg      <= tag_now;
      mode_reg        <= mode_now;
    end
  end

  // ---------------------------------------------------------------------
  // Memory latency compensation (t+1+RD_LAT)
  // ---------------------------------------------------------------------
  vid_tag_t tag_d;

  vga_delay_line #(
    .WIDTH   (TAG_W),
    .DEPTH   (RD_LAT),
    .RST_VAL ('0)
  ) u_tag_delay (
    .clk   (CLK_25_I),
    .rst_n (RST_N_I),
    .din   (tag_s1_reg),
    .dout  (tag_d)
  );

  // ---------------------------------------------------------------------
  // Output stage (t+2+RD_LAT)
  // ---------------------------------------------------------------------
  logic [COLOR_W-1:0] red_next, green_next, blue_next;
  logic [COLOR_W-1:0] red_reg, green_reg, blue_reg;
  logic               hsync_reg, vsync_reg, video_en_reg;

  // Pick bar colour or memory data; blank outside the visible area
  always_comb begin
    red_next   = '0;
    green_next = '0;
    blue_next  = '0;
    if (tag_d.active) begin
      if (tag_d.mode == MODE_BARS) begin
        red_next   = {COLOR_W{tag_d.bar[2]}};
        green_next = {COLOR_W{tag_d.bar[1]}};
        blue_next  = {COLOR_W{tag_d.bar[0]}};
      end else begin
        red_next   = VIDEO_PXL_I[3*COLOR_W-1 -: COLOR_W];
        green_next = VIDEO_PXL_I[2*COLOR_W-1 -: COLOR_W];
        blue_next  = VIDEO_PXL_I[COLOR_W-1:0];
      end
    end
  end

  // Final register so sync, enable and colour change on the same edge
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      hsync_reg    <= ~SYNC_POL;
      vsync_reg    <= ~SYNC_POL;
      video_en_reg <= 1'b0;
      red_reg      <= '0;
      green_reg    <= '0;
      blue_reg     <= '0;
    end else begin
      hsync_reg    <= tag_d.hs ? SYNC_POL : ~SYNC_POL;
      vsync_reg    <= tag_d.vs ? SYNC_POL : ~SYNC_POL;
      video_en_reg <= tag_d.active;
      red_reg      <= red_next;
      green_reg    <= green_next;
      blue_reg     <= blue_next;
    end
  end

  assign ADDRESS_O     = address_reg;
  assign FRAME_START_O = frame_start_reg;
  assign HSYNC_O       = hsync_reg;
  assign VSYNC_O       = vsync_reg;
  assign VIDEO_EN_O    = video_en_reg;
  assign RED_O         = red_reg;
  assign GREEN_O       = green_reg;
  assign BLUE_O        = blue_reg;

endmodule
